// File: rtl/conv1_kernel_fetch_if.sv
// Weight-pair stream from the conv1 kernel fetcher to the conv1 MAC array.
// The producer side is the fetcher; the consumer owns out_ready.
interface conv1_kernel_fetch_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_b_valid;
  logic              last;

  modport master (
    output out_valid,
    output w_a,
    output w_b,
    output w_b_valid,
    output last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  w_a,
    input  w_b,
    input  w_b_valid,
    input  last,
    output out_ready
  );
endinterface

// File: rtl/conv1_kernel_fetch.sv
// conv1 kernel weight fetch sequencer.
// Walks one filter's weights out of a dual-port, one-cycle registered-read
// ROM, two offsets per cycle, and hands weight pairs to the MAC array over a
// valid/ready stream. A 2-stage valid/tag pipe tracks reads through the ROM
// latency and a 4-entry FIFO absorbs consumer backpressure.
module conv1_kernel_fetch #(
  parameter int KERNEL_SIZE = 25,
  parameter int NUM_FILTERS = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        filter_idx,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  conv1_kernel_fetch_if.master st
);

  localparam int NUM_PAIRS = (KERNEL_SIZE + 1) / 2;
  localparam int PAIR_W    = $clog2(NUM_PAIRS + 1);
  localparam int FIFO_D    = 4;

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [ADDR_W-1:0] KS_A      = ADDR_W'(KERNEL_SIZE);
  localparam bit                ODD_K     = (KERNEL_SIZE % 2) == 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bv;
    logic              lst;
  } pair_t;

  state_t state, state_n;

  // Fetch context: filter base address and index of the next pair to issue.
  logic [ADDR_W-1:0] base_q;
  logic [PAIR_W-1:0] pair_cnt;

  // Issue stage (combinational): the read launched at the coming edge.
  logic              vld_p0;
  logic [ADDR_W-1:0] base_p0;
  logic [PAIR_W-1:0] pair_p0;
  logic              last_p0;
  logic              odd_p0;
  logic [ADDR_W-1:0] addr_a_p0;
  logic [ADDR_W-1:0] addr_b_p0;

  // Address stage: address registers are driving the ROM.
  logic              vld_p1;
  logic              wbv_p1;
  logic              last_p1;

  // ROM stage: q_a/q_b hold the data for this read.
  logic              vld_p2;
  logic              wbv_p2;
  logic              last_p2;

  // Output FIFO.
  pair_t             fifo_mem [FIFO_D];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_count;
  pair_t             head;
  logic              head_vld;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] start_base;
  logic              start_ok;
  logic              fetch_last;
  logic [1:0]        inflight;
  logic [3:0]        occupancy;
  logic              room;
  logic              done_n;
  logic              start_err_n;

  assign start_base = ADDR_W'(filter_idx) * KS_A;
  assign start_ok   = int'(filter_idx) < NUM_FILTERS;
  assign fetch_last = (pair_cnt == LAST_PAIR);

  // A read may only be launched if a FIFO slot is guaranteed for it once it
  // returns, counting reads still travelling through the ROM.
  assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2};
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign room      = occupancy < 4'(FIFO_D);

  assign head     = fifo_mem[rd_ptr];
  assign head_vld = (fifo_count != 3'd0);
  assign push     = vld_p2;
  assign pop      = head_vld && st.out_ready;

  // The final pair of an odd kernel reads the same word on both ports and
  // marks the odd slot empty.
  assign last_p0   = (pair_p0 == LAST_PAIR);
  assign odd_p0    = last_p0 && ODD_K;
  assign addr_a_p0 = base_p0 + ADDR_W'({pair_p0, 1'b0});
  assign addr_b_p0 = odd_p0 ? addr_a_p0 : addr_a_p0 + ADDR_W'(1);

  // busy stays up through the done cycle even though the state is IDLE then.
  assign busy = (state != IDLE) || done;

  assign st.out_valid = head_vld;
  assign st.w_a       = head_vld ? head.a   : '0;
  assign st.w_b       = head_vld ? head.b   : '0;
  assign st.w_b_valid = head_vld ? head.bv  : 1'b0;
  assign st.last      = head_vld ? head.lst : 1'b0;

  // Next-state, issue decision and status pulses.
  always_comb begin
    state_n     = state;
    vld_p0      = 1'b0;
    base_p0     = base_q;
    pair_p0     = pair_cnt;
    done_n      = 1'b0;
    start_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            vld_p0  = 1'b1;
            base_p0 = start_base;
            pair_p0 = '0;
            state_n = (NUM_PAIRS == 1) ? DRAIN : FETCH;
          end else begin
            start_err_n = 1'b1;
          end
        end
      end
      FETCH: begin
        if (room) begin
          vld_p0 = 1'b1;
          if (fetch_last) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Every read has been issued; the last-tagged pair leaving the FIFO
        // means nothing is left in flight.
        if (pop && head.lst) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, fetch context, ROM addresses and stage valids.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      pair_cnt  <= '0;
      address_a <= '0;
      address_b <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= done_n;
      start_err <= start_err_n;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      if (vld_p0) begin
        base_q    <= base_p0;
        pair_cnt  <= pair_p0 + PAIR_W'(1);
        address_a <= addr_a_p0;
        address_b <= addr_b_p0;
      end
    end
  end

  // Pair tags travel beside the valids; the valids alone qualify them.
  always_ff @(posedge clock) begin
    // issue -> address stage
    if (vld_p0) begin
      wbv_p1  <= !odd_p0;
      last_p1 <= last_p0;
    end
    // address stage -> ROM stage
    wbv_p2  <= wbv_p1;
    last_p2 <= last_p1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ROM stage -> FIFO: capture returning data with its tags.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{a:   q_a,
                            b:   wbv_p2 ? q_b : '0,
                            bv:  wbv_p2,
                            lst: last_p2};
    end
  end

endmodule

// File: tb/tb_conv1_kernel_fetch.sv
// Directed bench for conv1_kernel_fetch against a ROM preloaded with
// rom[i] = i, so every weight equals its own address.
module tb_conv1_kernel_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  filter_idx;
  logic        busy;
  logic        done;
  logic        start_err;
  logic [6:0]  address_a;
  logic [6:0]  address_b;
  logic [15:0] q_a;
  logic [15:0] q_b;
  logic [15:0] rom [128];

  int n_vec = 0;
  int n_err = 0;

  conv1_kernel_fetch_if #(.DATA_W(16)) st ();

  conv1_kernel_fetch #(
    .KERNEL_SIZE(25),
    .NUM_FILTERS(5),
    .ADDR_W(7),
    .DATA_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .filter_idx(filter_idx),
    .busy(busy),
    .done(done),
    .start_err(start_err),
    .address_a(address_a),
    .address_b(address_b),
    .q_a(q_a),
    .q_b(q_b),
    .st(st)
  );

  always #5 clock = ~clock;

  // One-cycle registered-read dual-port ROM.
  always_ff @(posedge clock) begin
    q_a <= rom[address_a];
    q_b <= rom[address_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_start_err"}, start_err, 0);
    check({tag, "_out_valid"}, st.out_valid, 0);
    check({tag, "_last"}, st.last, 0);
    check({tag, "_w_b_valid"}, st.w_b_valid, 0);
    check({tag, "_w_a"}, st.w_a, 0);
    check({tag, "_w_b"}, st.w_b, 0);
    check({tag, "_address_a"}, address_a, 0);
    check({tag, "_address_b"}, address_b, 0);
  endtask

  // Presents start for one cycle (the current cycle is cycle 0) and returns in cycle 1.
  task automatic start_fetch(input int f);
    filter_idx = 3'(f);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Consumes a stream for filter f starting in the current cycle, checking
  // order, content, hold-under-stall and address range; returns in the done cycle.
  task automatic drain(input int f, input bit rnd);
    int          k = 0;
    bit          got_done = 0;
    bit          prev_stall = 0;
    bit          rdy;
    logic [15:0] pa, pb;
    logic        pv, pl;
    int          ea, eb;
    for (int n = 0; n < 300 && !got_done; n++) begin
      if (prev_stall) begin
        check("hold_valid", st.out_valid, 1);
        check("hold_w_a", st.w_a, pa);
        check("hold_w_b", st.w_b, pb);
        check("hold_w_b_valid", st.w_b_valid, pv);
        check("hold_last", st.last, pl);
      end
      check("addr_in_range", (address_a <= 7'd124) && (address_b <= 7'd124), 1);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      st.out_ready = rdy;
      if (st.out_valid && rdy) begin
        if (k < 13) begin
          ea = f * 25 + 2 * k;
          eb = (k == 12) ? 0 : ea + 1;
          check("pair_w_a", st.w_a, ea);
          check("pair_w_b", st.w_b, eb);
          check("pair_w_b_valid", st.w_b_valid, (k == 12) ? 0 : 1);
          check("pair_last", st.last, (k == 12) ? 1 : 0);
        end else begin
          check("extra_pair", k, 12);
        end
        k++;
      end
      prev_stall = st.out_valid && !rdy;
      pa = st.w_a;
      pb = st.w_b;
      pv = st.w_b_valid;
      pl = st.last;
      if (done) begin
        got_done = 1;
      end else begin
        tick();
      end
    end
    check("pair_count", k, 13);
    check("done_seen", got_done, 1);
    st.out_ready = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] sa, sb;
    int         ea;
    for (int i = 0; i < 128; i++) rom[i] = 16'(i);
    reset        = 1'b1;
    start        = 1'b0;
    filter_idx   = 3'd0;
    st.out_ready = 1'b0;

    // Reset state, held and after release.
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Filter 0 with out_ready high: exact cycle timing, plus an ignored
    // second start (filter 3) in the middle of the fetch.
    st.out_ready = 1'b1;
    filter_idx   = 3'd0;
    start        = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      start = 1'b0;
      check("t0_busy", busy, (c <= 16) ? 1 : 0);
      check("t0_done", done, (c == 16) ? 1 : 0);
      check("t0_start_err", start_err, 0);
      check("t0_out_valid", st.out_valid, (c >= 3 && c <= 15) ? 1 : 0);
      if (c >= 3 && c <= 15) begin
        ea = 2 * (c - 3);
        check("t0_w_a", st.w_a, ea);
        check("t0_w_b", st.w_b, (c == 15) ? 0 : ea + 1);
        check("t0_w_b_valid", st.w_b_valid, (c == 15) ? 0 : 1);
        check("t0_last", st.last, (c == 15) ? 1 : 0);
      end
      if (c == 1) begin
        check("t0_addr_a_first", address_a, 0);
        check("t0_addr_b_first", address_b, 1);
      end
      if (c == 13 || c == 18) begin
        check("t0_addr_a_final", address_a, 24);
        check("t0_addr_b_final", address_b, 24);
      end
      if (c == 5) begin
        filter_idx = 3'd3;
        start      = 1'b1;
      end
    end

    // Out-of-range filter indices in IDLE.
    for (int bad = 5; bad <= 7; bad += 2) begin
      sa = address_a;
      sb = address_b;
      start_fetch(bad);
      check("bad_start_err_pulse", start_err, 1);
      check("bad_busy1", busy, 0);
      tick();
      check("bad_start_err_clear", start_err, 0);
      check("bad_busy2", busy, 0);
      check("bad_out_valid", st.out_valid, 0);
      check("bad_addr_a", address_a, sa);
      check("bad_addr_b", address_b, sb);
    end

    // Filter 4: range top, no address beyond 124.
    tick();
    start_fetch(4);
    drain(4, 0);
    check("f4_addr_a_end", address_a, 124);

    // Full backpressure on filter 0: issue stops after four pairs.
    tick();
    st.out_ready = 1'b0;
    start_fetch(0);
    repeat (19) tick();
    check("stall_addr_a", address_a, 6);
    check("stall_addr_b", address_b, 7);
    check("stall_out_valid", st.out_valid, 1);
    check("stall_w_a", st.w_a, 0);
    check("stall_w_b", st.w_b, 1);
    check("stall_busy", busy, 1);
    drain(0, 0);

    // Random backpressure on filter 2.
    tick();
    start_fetch(2);
    drain(2, 1);

    // Reset in cycle 6 of a stalled fetch discards everything.
    tick();
    st.out_ready = 1'b0;
    start_fetch(2);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset        = 1'b0;
    st.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("midrst_no_valid", st.out_valid, 0);
      check("midrst_no_done", done, 0);
      check("midrst_no_busy", busy, 0);
    end

    // Back-to-back: filter 3 started in filter 1's done cycle.
    tick();
    start_fetch(1);
    drain(1, 0);
    filter_idx = 3'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_ov_c1", st.out_valid, 0);
    check("b2b_addr_a", address_a, 75);
    tick();
    check("b2b_ov_c2", st.out_valid, 0);
    tick();
    check("b2b_ov_c3", st.out_valid, 1);
    check("b2b_first_w_a", st.w_a, 75);
    drain(3, 0);
    tick();
    check("b2b_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv1_kernel_fetch.md
# conv1_kernel_fetch

Read-side sequencer for the conv1 kernel weight ROMs (128 x 16-bit, dual-port, one-cycle registered read). On a start request for one filter it walks that filter's 25 weights two addresses per cycle over both ROM ports. It absorbs the ROM read latency and delivers weight pairs to the conv1 MAC array over a valid/ready stream with full backpressure. It sits between a conv1_k_gN weight ROM and the conv1 datapath controller, one instance per group.

## Interface
- KERNEL_SIZE, 25: weights per filter (5x5).
- NUM_FILTERS, 5: filters stored per ROM; filter f occupies addresses f*KERNEL_SIZE .. f*KERNEL_SIZE+KERNEL_SIZE-1.
- ADDR_W, 7: ROM address width.
- DATA_W, 16: weight width.
- clock  in  1  single clock for all logic; ROM shares it.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a fetch; sampled only in IDLE.
- filter_idx  in  3  filter to fetch, sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final pair handshake.
- start_err  out  1  one-cycle pulse when start arrives in IDLE with filter_idx >= NUM_FILTERS.
- address_a, address_b  out  ADDR_W  registered ROM read addresses.
- q_a, q_b  in  DATA_W  ROM read data, valid one cycle after the address.
- out_valid  out  1  weight pair available.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- w_a, w_b  out  DATA_W  weights at even and odd kernel offsets of the pair.
- w_b_valid  out  1  low only on the final pair of an odd-sized kernel; w_b = 0 then.
- last  out  1  marks the final pair.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE -> FETCH: start=1 and filter_idx < NUM_FILTERS. base = filter_idx*KERNEL_SIZE, pair counter = 0. If filter_idx is out of range, pulse start_err and stay in IDLE.
- start in FETCH or DRAIN is ignored, with no start_err.
- FETCH issue rule: a read is issued in a cycle when fifo_count + inflight < 4.
  - inflight = reads at the address stage or ROM stage not yet written to the FIFO.
  - An issue drives address_a = base+2k and address_b = base+2k+1.
  - On the final pair of an odd kernel, address_b = address_a and the odd slot is tagged invalid.
- Pair count = ceil(KERNEL_SIZE/2); 13 for the defaults.
- FETCH -> DRAIN when the last pair has been issued.
- DRAIN -> IDLE when the FIFO is empty and no reads are in flight, after the last pair handshakes. done pulses in the cycle busy falls.
- Read tracking: a 2-stage valid/tag pipe follows the ROM latency. The ROM-stage entry writes {q_a, q_b or 0, w_b_valid, last} into a 4-deep output FIFO.
- The FIFO head drives w_a, w_b, w_b_valid, last, out_valid.
- Address arithmetic is ADDR_W unsigned. The maximum address (NUM_FILTERS*KERNEL_SIZE-1 = 124) never wraps.
- When no read is issued, address_a/address_b hold their last value.

## Timing
- Reset values: busy=0, done=0, start_err=0, out_valid=0, last=0, w_b_valid=0, w_a=w_b=0, address_a=address_b=0. FIFO is emptied, in-flight tags are cleared, state = IDLE.
- Reset mid-fetch: all in-flight data is discarded. No out_valid or done follows. ROM data returning after reset is ignored.
- Latency with start in cycle 0: addresses valid in cycle 1, q in cycle 2, out_valid in cycle 3.
- Throughput with out_ready held high: one pair per cycle, so pairs appear in cycles 3..15, last in cycle 15, done in cycle 16, busy high in cycles 1..16.
- Backpressure: w_a, w_b, w_b_valid and last are stable while out_valid && !out_ready. There are no drops or duplicates. Issue stalls within 2 cycles of the FIFO filling; at most 4 pairs are buffered.
- start_err pulses in the cycle after the bad start.
- Back-to-back: a start in the cycle done is high is accepted, because the state is already IDLE.

## Test plan
- Filter 0, out_ready=1, ROM preloaded with rom[i]=i: 13 pairs (0,1),(2,3)..(22,23), then (24,0) with w_b_valid=0 and last=1; out_valid cycles 3..15, done in cycle 16.
- Filter 4: first pair (100,101), final w_a=124, and no address above 124 is issued.
- Random out_ready (50%) on filter 2: the sequence is 50..74 in order with no loss or duplication, outputs hold while stalled, and the FIFO never exceeds 4 entries.
- filter_idx=5 in IDLE: start_err pulse in the next cycle, busy stays 0, addresses unchanged; a second start during an active fetch has no effect.
- Reset asserted in cycle 6 of a fetch with out_ready=0: all outputs at reset values the next cycle, and no out_valid for 5 cycles afterwards.
- Back-to-back fetches, filter 1 then filter 3 started in the done cycle: second stream 75..99, with out_valid 3 cycles after the second start.
